// File: rtl/cic_interp.sv
`timescale 1ns/1ps
// CIC interpolator: a one-entry input buffer feeds a low-rate comb section; zero-stuffed
// integrators run at the high rate, one step per out_ena_i strobe.
module cic_interp #(
    parameter int WIDTH_I       = 16,
    parameter int WIDTH_O       = 17,
    parameter int STAGES        = 4,
    parameter int INTERPOLATION = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH_I-1:0] data_i,
    input  logic               data_val_i,
    output logic               ready_o,
    input  logic               out_ena_i,
    output logic [WIDTH_O-1:0] data_o,
    output logic               data_val_o,
    output logic               underrun_o
);
    localparam int L = $clog2(INTERPOLATION);
    localparam int G = (STAGES - 1) * L;
    localparam int W = WIDTH_I + G;
    localparam logic [L-1:0] PH_LAST = L'(INTERPOLATION - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [L-1:0]              phase_q, phase_d;
    logic                      buf_full_q;
    logic [WIDTH_I-1:0]        buf_q;
    logic                      consume, step, underrun_d, accept;

    logic [STAGES-1:0][W-1:0]  comb_d_q, comb_in;
    logic [W-1:0]              comb_out, comb_q;
    logic [STAGES-1:0][W-1:0]  integ_q, integ_nxt;
    logic [W-1:0]              integ_out;

    // A sample may land in the same cycle the buffer is drained into the comb chain.
    assign ready_o = rst_i & (~buf_full_q | consume);
    assign accept  = data_val_i & ready_o;

    always_comb begin
        comb_in  = '0;
        comb_out = W'($signed(buf_q));
        for (int i = 0; i < STAGES; i++) begin
            comb_in[i] = comb_out;
            comb_out   = comb_out - comb_d_q[i];
        end
    end

    // Integrator input is zero-stuffed: the comb result enters only at phase 0.
    always_comb begin
        integ_nxt = '0;
        integ_out = (phase_q == '0) ? comb_q : '0;
        for (int i = 0; i < STAGES; i++) begin
            integ_out    = integ_q[i] + integ_out;
            integ_nxt[i] = integ_out;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        consume    = 1'b0;
        step       = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    consume = 1'b1;
                    phase_d = '0;
                    state_d = RUN;
                end else if (out_ena_i) begin
                    underrun_d = 1'b1;
                end
            end
            RUN: begin
                if (out_ena_i) begin
                    step = 1'b1;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (buf_full_q) consume = 1'b1;
                        else            state_d = IDLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            comb_d_q   <= '0;
            comb_q     <= '0;
            integ_q    <= '0;
            data_o     <= '0;
            data_val_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            data_val_o <= step;
            underrun_o <= underrun_d;
            if (accept) begin
                buf_q      <= data_i;
                buf_full_q <= 1'b1;
            end else if (consume) begin
                buf_full_q <= 1'b0;
            end
            if (consume) begin
                comb_d_q <= comb_in;
                comb_q   <= comb_out;
            end
            if (step) begin
                integ_q <= integ_nxt;
                data_o  <= integ_out[W-1 -: WIDTH_O];
            end
        end
    end
endmodule

// File: tb/tb_cic_interp.sv
`timescale 1ns/1ps
// Bench for cic_interp: outputs are compared with a convolution model built from the
// CIC impulse response (box filter of length R convolved STAGES times).
module tb_cic_interp;
    localparam int WI   = 16;
    localparam int WO   = 17;
    localparam int N    = 4;
    localparam int R    = 8;
    localparam int G    = (N - 1) * 3;
    localparam int W    = WI + G;
    localparam int HLEN = N * (R - 1) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [WI-1:0] data_i;
    logic          data_val_i;
    logic          ready_o;
    logic          out_ena_i;
    logic [WO-1:0] data_o;
    logic          data_val_o;
    logic          underrun_o;

    int     nchk = 0;
    int     nerr = 0;
    int     cyc  = 0;
    int     acc_q[$];
    int     out_q[$];
    int     n_underrun;
    int     first_acc_cyc, first_out_cyc;
    longint h [HLEN];

    cic_interp #(.WIDTH_I(WI), .WIDTH_O(WO), .STAGES(N), .INTERPOLATION(R)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_val_i(data_val_i),
        .ready_o(ready_o), .out_ena_i(out_ena_i), .data_o(data_o),
        .data_val_o(data_val_o), .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && data_val_i === 1'b1 && ready_o === 1'b1) begin
            acc_q.push_back(int'($signed(data_i)));
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (data_val_o === 1'b1) begin
            out_q.push_back(int'($signed(data_o)));
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (underrun_o === 1'b1) n_underrun = n_underrun + 1;
    end

    task automatic build_h();
        longint cur [HLEN];
        longint nxt [HLEN];
        for (int i = 0; i < HLEN; i++) cur[i] = 0;
        cur[0] = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < HLEN; i++) begin
                nxt[i] = 0;
                for (int j = 0; j < R; j++) if (i - j >= 0) nxt[i] += cur[i-j];
            end
            cur = nxt;
        end
        h = cur;
    endtask

    // Output k of the high-rate stream: sample n is injected at step n*R; sum is taken
    // modulo 2^W and the top WO bits are kept.
    function automatic int model_out(int k);
        longint            s;
        logic signed [W-1:0] w;
        logic signed [W-1:0] sh;
        s = 0;
        for (int n = 0; n < acc_q.size() && n * R <= k; n++) begin
            if (k - n * R < HLEN) s += longint'(acc_q[n]) * h[k - n * R];
        end
        w  = s[W-1:0];
        sh = w >>> (W - WO);
        return int'(sh);
    endfunction

    task automatic clear_model();
        acc_q.delete();
        out_q.delete();
        n_underrun    = 0;
        first_acc_cyc = -1;
        first_out_cyc = -1;
    endtask

    task automatic apply_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0; data_val_i = 1'b0; out_ena_i = 1'b0; data_i = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        rst_i = 1'b0; data_val_i = 1'b1; data_i = 16'h1234; out_ena_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        nchk++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b, expected 0", ready_o); end
        nchk++; if (data_o !== '0) begin nerr++; $display("FAIL reset_data: got %0h, expected 0", data_o); end
        nchk++; if (data_val_o !== 1'b0) begin nerr++; $display("FAIL reset_val: got %b, expected 0", data_val_o); end
        nchk++; if (underrun_o !== 1'b0) begin nerr++; $display("FAIL reset_underrun: got %b, expected 0", underrun_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b1; data_val_i = 1'b0; out_ena_i = 1'b0;
        clear_model();
        @(negedge clk_i);
        nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL release_ready: got %b, expected 1", ready_o); end
    endtask

    task automatic test_impulse();
        apply_reset();
        data_i = 16'd1; data_val_i = 1'b1; out_ena_i = 1'b1;
        @(posedge clk_i); #1;
        data_i = '0;
        for (int i = 0; i < 300 && out_q.size() < R * N; i++) @(posedge clk_i);
        #1; data_val_i = 1'b0; out_ena_i = 1'b0;
        nchk++; if (out_q.size() < R * N) begin nerr++; $display("FAIL impulse_count: got %0d, expected %0d", out_q.size(), R * N); end
        nchk++;
        if (first_out_cyc < 0 || first_out_cyc - first_acc_cyc > 3 || first_out_cyc <= first_acc_cyc) begin
            nerr++; $display("FAIL impulse_latency: got %0d cycles, expected 1..3", first_out_cyc - first_acc_cyc);
        end
        for (int k = 0; k < out_q.size() && k < R * N; k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL impulse_out[%0d]: got %0d, expected %0d", k, out_q[k], e); end
        end
    endtask

    task automatic test_step(input bit do_reset, input string tag);
        if (do_reset) apply_reset();
        data_i = 16'd1000; data_val_i = 1'b1; out_ena_i = 1'b0;
        @(posedge clk_i); #1;
        out_ena_i = 1'b1;
        for (int i = 0; i < 400 && out_q.size() < N * R + 24; i++) @(posedge clk_i);
        #1; data_val_i = 1'b0; out_ena_i = 1'b0;
        nchk++; if (out_q.size() < N * R + 24) begin nerr++; $display("FAIL %s_count: got %0d, expected %0d", tag, out_q.size(), N * R + 24); end
        nchk++; if (n_underrun !== 0) begin nerr++; $display("FAIL %s_underrun: got %0d, expected 0", tag, n_underrun); end
        for (int k = 0; k < out_q.size(); k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL %s_model[%0d]: got %0d, expected %0d", tag, k, out_q[k], e); end
            if (k >= N * R) begin
                nchk++; if (out_q[k] !== 2000) begin nerr++; $display("FAIL %s_dc[%0d]: got %0d, expected 2000", tag, k, out_q[k]); end
            end
        end
    endtask

    task automatic test_pacing();
        int bp;
        int ur_run;
        apply_reset();
        bp = 0;
        data_i = 16'd777; data_val_i = 1'b1; out_ena_i = 1'b0;
        for (int i = 0; i < 8 * R * 6; i++) begin
            out_ena_i = (i % 8 == 7);
            @(negedge clk_i);
            if (data_val_i && !ready_o) bp++;
            @(posedge clk_i); #1;
        end
        ur_run = n_underrun;
        data_val_i = 1'b0;
        for (int i = 0; i < 8 * R * 3; i++) begin
            out_ena_i = (i % 8 == 7);
            @(posedge clk_i); #1;
        end
        out_ena_i = 1'b0;
        nchk++; if (bp == 0) begin nerr++; $display("FAIL pacing_backpressure: got %0d stalled cycles, expected >0", bp); end
        nchk++; if (ur_run !== 0) begin nerr++; $display("FAIL pacing_underrun: got %0d, expected 0", ur_run); end
        nchk++; if (acc_q.size() < 6) begin nerr++; $display("FAIL pacing_accepts: got %0d, expected >=6", acc_q.size()); end
        nchk++; if (out_q.size() !== R * acc_q.size()) begin nerr++; $display("FAIL pacing_ratio: got %0d outputs, expected %0d", out_q.size(), R * acc_q.size()); end
        for (int k = 0; k < out_q.size(); k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL pacing_out[%0d]: got %0d, expected %0d", k, out_q[k], e); end
        end
    endtask

    task automatic test_starvation();
        int ur_before;
        apply_reset();
        data_val_i = 1'b1; data_i = WI'($urandom); out_ena_i = 1'b0;
        for (int i = 0; i < 300 && out_q.size() < 4 * R; i++) begin
            @(posedge clk_i); #1;
            data_i = WI'($urandom);
            if (acc_q.size() >= 1) out_ena_i = 1'b1;
            if (acc_q.size() >= 4) data_val_i = 1'b0;
        end
        ur_before = n_underrun;
        nchk++; if (out_q.size() !== 4 * R) begin nerr++; $display("FAIL starve_count: got %0d, expected %0d", out_q.size(), 4 * R); end
        nchk++; if (ur_before !== 0) begin nerr++; $display("FAIL starve_early_underrun: got %0d, expected 0", ur_before); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            nchk++;
            if (underrun_o !== 1'b1 || data_val_o !== 1'b0) begin
                nerr++; $display("FAIL starve_idle[%0d]: got underrun=%b val=%b, expected 1/0", i, underrun_o, data_val_o);
            end
        end
        nchk++; if (out_q.size() !== 4 * R) begin nerr++; $display("FAIL starve_extra: got %0d outputs, expected %0d", out_q.size(), 4 * R); end
        @(posedge clk_i); #1;
        data_val_i = 1'b1;
        for (int i = 0; i < 400 && out_q.size() < 8 * R; i++) begin
            @(posedge clk_i); #1;
            data_i = WI'($urandom);
            if (acc_q.size() >= 8) data_val_i = 1'b0;
        end
        data_val_i = 1'b0; out_ena_i = 1'b0;
        nchk++; if (out_q.size() !== 8 * R) begin nerr++; $display("FAIL resume_count: got %0d, expected %0d", out_q.size(), 8 * R); end
        for (int k = 0; k < out_q.size(); k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL starve_out[%0d]: got %0d, expected %0d", k, out_q[k], e); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit;
        int bad;
        apply_reset();
        data_i = 16'd1000; data_val_i = 1'b1; out_ena_i = 1'b0;
        @(posedge clk_i); #1;
        out_ena_i = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk_i); #1;
            if (out_q.size() == 3) hit = 1'b1;
        end
        nchk++; if (!hit) begin nerr++; $display("FAIL midrst_start: got %0d outputs, expected 3", out_q.size()); end
        rst_i = 1'b0;
        nchk++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL midrst_ready_low: got %b, expected 0", ready_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b1; data_val_i = 1'b0; out_ena_i = 1'b0;
        clear_model();
        @(negedge clk_i);
        nchk++; if (data_o !== '0) begin nerr++; $display("FAIL midrst_data: got %0h, expected 0", data_o); end
        nchk++; if (data_val_o !== 1'b0) begin nerr++; $display("FAIL midrst_val: got %b, expected 0", data_val_o); end
        nchk++; if (underrun_o !== 1'b0) begin nerr++; $display("FAIL midrst_underrun: got %b, expected 0", underrun_o); end
        nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b, expected 1", ready_o); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (data_val_o !== 1'b0) bad++;
        end
        nchk++; if (bad !== 0) begin nerr++; $display("FAIL midrst_quiet: got %0d pulses, expected 0", bad); end
        clear_model();
        test_step(1'b0, "step_after_rst");
    endtask

    task automatic test_extremes();
        apply_reset();
        data_i = 16'h8000; data_val_i = 1'b1; out_ena_i = 1'b0;
        for (int i = 0; i < 400 && out_q.size() < 12 * R; i++) begin
            @(posedge clk_i); #1;
            out_ena_i = 1'b1;
            data_i = (acc_q.size() % 2 == 1) ? 16'h7FFF : 16'h8000;
        end
        data_val_i = 1'b0; out_ena_i = 1'b0;
        nchk++; if (out_q.size() < 12 * R) begin nerr++; $display("FAIL extreme_count: got %0d, expected %0d", out_q.size(), 12 * R); end
        for (int k = 0; k < out_q.size(); k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL extreme_out[%0d]: got %0d, expected %0d", k, out_q[k], e); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            data_val_i = ($urandom_range(0, 9) < 6);
            data_i     = WI'($urandom);
            out_ena_i  = ($urandom_range(0, 3) != 0);
            @(posedge clk_i); #1;
        end
        data_val_i = 1'b0; out_ena_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1; out_ena_i = 1'b0;
        nchk++; if (out_q.size() !== R * acc_q.size()) begin nerr++; $display("FAIL random_ratio: got %0d outputs, expected %0d", out_q.size(), R * acc_q.size()); end
        for (int k = 0; k < out_q.size(); k++) begin
            int e;
            e = model_out(k);
            nchk++; if (out_q[k] !== e) begin nerr++; $display("FAIL random_out[%0d]: got %0d, expected %0d", k, out_q[k], e); end
        end
    endtask

    initial begin
        rst_i = 1'b0; data_val_i = 1'b0; out_ena_i = 1'b0; data_i = '0;
        clear_model();
        build_h();
        test_reset();
        test_impulse();
        test_step(1'b1, "step");
        test_pacing();
        test_starvation();
        test_reset_mid_run();
        test_extremes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 The block SHALL have parameter WIDTH_I, default 16, input sample width, signed.
REQ-002 The block SHALL have parameter WIDTH_O, default 17, output sample width, signed, WIDTH_I <= WIDTH_O <= WIDTH_I+G.
REQ-003 The block SHALL have parameter STAGES, default 4, number of comb and of integrator stages, range 1..8.
REQ-004 The block SHALL have parameter INTERPOLATION, default 8, rate change R, power of two, range 2..64.
REQ-005 The block SHALL use derived constants L = log2(R), G = (STAGES-1)*L and internal width W = WIDTH_I+G.
REQ-006 The block SHALL have port clk_i, input, 1 bit, the only clock.
REQ-007 The block SHALL have port rst_i, input, 1 bit, synchronous active-low reset.
REQ-008 The block SHALL have port data_i, input, WIDTH_I bits, low-rate sample.
REQ-009 The block SHALL have port data_val_i, input, 1 bit, data_i valid.
REQ-010 The block SHALL have port ready_o, output, 1 bit, input buffer can accept.
REQ-011 The block SHALL have port out_ena_i, input, 1 bit, output sample request strobe, paces the high rate.
REQ-012 The block SHALL have port data_o, output, WIDTH_O bits, interpolated sample.
REQ-013 The block SHALL have port data_val_o, output, 1 bit, one-cycle pulse per output sample.
REQ-014 The block SHALL have port underrun_o, output, 1 bit, one-cycle pulse on a starved request.

Function
REQ-015 Input accept SHALL occur when data_val_i && ready_o, capturing data_i into a one-entry buffer; ready_o = buffer empty OR buffer being consumed this cycle.
REQ-016 The comb section SHALL run once per consumed buffer entry: STAGES cascaded y = x - x_prev at width W (input sign-extended), with comb delay registers updating only on consume; the chain result is registered (comb_q).
REQ-017 FSM states SHALL be IDLE and RUN, with phase counter 0..R-1.
REQ-018 In IDLE, when the buffer is full, the block SHALL consume it into the comb chain, set phase=0 and go to RUN on the next cycle.
REQ-019 In RUN, on each out_ena_i, the integrator input SHALL be comb_q when phase==0 else 0; all STAGES integrators (y = y + x, width W, two's-complement wrap) SHALL step once.
REQ-020 At phase R-1 with out_ena_i: if the buffer is full, it SHALL be consumed in the same cycle, comb_q updated and phase set to 0 (gapless); else the block SHALL go to IDLE.
REQ-021 Outside these steps phase SHALL advance by 1 per out_ena_i; no step SHALL occur without out_ena_i.
REQ-022 Each integrator step SHALL register data_o = last integrator bits [WIDTH_I+G-1 : WIDTH_I+G-WIDTH_O] (truncation, no rounding) and assert data_val_o the following cycle; a step occurring on cycle t SHALL produce data_val_o high on cycle t+1.
REQ-023 DC gain SHALL therefore be 2^(WIDTH_O-WIDTH_I).
REQ-024 When out_ena_i is high in IDLE, the block SHALL pulse underrun_o, leave integrators frozen and produce no data_val_o.
REQ-025 Simultaneous accept and consume SHALL be lossless: the buffer is refilled in the same cycle.
REQ-026 Integrator and comb overflow SHALL wrap silently; the truncated output is exact for inputs within WIDTH_I.

Reset
REQ-027 On clk_i rising edge with rst_i low, all comb, integrator, buffer and output registers SHALL clear to 0, state SHALL be IDLE and phase 0.
REQ-028 During reset, ready_o SHALL be 0, data_o 0, data_val_o 0 and underrun_o 0; ready_o SHALL be 1 in the first cycle after release.
REQ-029 Reset asserted mid-RUN SHALL discard the buffered sample and all filter state without emitting a further data_val_o.

Verification
REQ-030 Impulse: defaults, out_ena_i=1, data_i=1 once then zeros -> summed integrator output before truncation over R*STAGES samples equals R^(STAGES-1)*R, and the first data_val_o occurs within 3 cycles of accept.
REQ-031 Step: defaults, data_i=1000 offered continuously, out_ena_i=1 -> after STAGES*R outputs, data_o holds 2000 for every sample, with no underrun_o pulses.
REQ-032 Pacing: out_ena_i high 1 cycle in 8, DC input -> exactly R data_val_o pulses per accepted sample; ready_o back-pressures, with no input loss or duplication.
REQ-033 Starvation: input stopped after 4 samples, out_ena_i=1 -> exactly 4*R data_val_o pulses, then underrun_o pulses each cycle; on resume the output continues without a discontinuity beyond the filter response.
REQ-034 Reset mid-run: rst_i low for 1 cycle during phase 3 -> all outputs 0 the next cycle, and a subsequent step test again yields 2000.
REQ-035 Extremes: data_i alternating -32768/32767 at full rate -> data_o matches a bit-true reference model and never exceeds the 17-bit range.
